regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port wr_en  input  1  write request, sampled every cycle.
REQ-004 SHALL have port wr_addr  input  4  write register index.
REQ-005 SHALL have port wr_data  input  16  write data.
REQ-006 SHALL have port rd_req  input  1  read request; accepted when rd_req and rd_ready are both high.
REQ-007 SHALL have port rd_addr1  input  4  read port-1 register index, captured on accept.
REQ-008 SHALL have port rd_addr2  input  4  read port-2 register index, captured on accept.
REQ-009 SHALL have port rd_ready  output  1  controller can accept a read.
REQ-010 SHALL have port rd_valid  output  1  rd_data1 and rd_data2 hold a completed read.
REQ-011 SHALL have port rd_data1  output  16  port-1 read result.
REQ-012 SHALL have port rd_data2  output  16  port-2 read result.
REQ-013 SHALL have port rd_ack  input  1  consumer accepts the result.
REQ-014 SHALL have port write_reg  output  16  one-hot per-register write enable.
REQ-015 SHALL have port reg_d  output  16  write data broadcast to all registers.
REQ-016 SHALL have port rden1  output  16  one-hot per-register bitline1 drive enable.
REQ-017 SHALL have port rden2  output  16  one-hot per-register bitline2 drive enable.
REQ-018 SHALL have port bitline1  input  16  shared read bus 1 driven by the selected register.
REQ-019 SHALL have port bitline2  input  16  shared read bus 2 driven by the selected register.

Function
REQ-020 SHALL implement a 3-state FSM: IDLE, SAMPLE and HOLD.
REQ-021 SHALL drive rd_ready high only in IDLE.
REQ-022 SHALL, in IDLE, on rd_req, latch rd_addr1 and rd_addr2 and go to SAMPLE; otherwise it SHALL stay in IDLE.
REQ-023 SHALL, in SAMPLE only, drive rden1 and rden2 one-hot from the latched addresses; rden1 and rden2 SHALL be all-zero in every other state.
REQ-024 SHALL, at the end of SAMPLE, register bitline1 into rd_data1 and bitline2 into rd_data2, then go to HOLD.
REQ-025 SHALL, in HOLD, assert rd_valid and keep rd_data1 and rd_data2 stable until rd_ack; on rd_ack it SHALL go to IDLE.
REQ-026 SHALL give a read latency of 2 cycles from accept to rd_valid.
REQ-027 SHALL NOT accept a new request in the cycle rd_ack is seen; the next accept is possible one cycle later, in IDLE.
REQ-028 SHALL treat index 0 as hardwired zero: for a latched address of 0, the corresponding rden bit SHALL stay low and the captured data SHALL be 16'h0000.
REQ-029 SHALL, when both latched addresses are equal and nonzero, assert the same bit in both rden1 and rden2.
REQ-030 SHALL, on wr_en in any state with wr_addr nonzero, drive write_reg one-hot from wr_addr in the same cycle; reg_d SHALL equal wr_data in every cycle.
REQ-031 SHALL keep write_reg all-zero when wr_en is low or wr_addr is 0.
REQ-032 SHALL, when a write and a SAMPLE read target the same register in the same cycle, capture data as defined in REQ-040 and REQ-041.

Reset
REQ-033 SHALL, while rst is low, force the FSM to IDLE, rd_valid to 0, and rd_data1 and rd_data2 to 16'h0000.
REQ-034 SHALL, while rst is low, force the latched addresses to 0 and write_reg, rden1 and rden2 to all-zero, regardless of wr_en.
REQ-035 SHALL abort any in-flight read when reset is asserted in SAMPLE or HOLD; no rd_valid for that read SHALL ever appear.
REQ-036 SHALL drive rd_ready high in the first cycle after rst is released.

Configuration
REQ-037 SHALL use the macro RF_BYPASS_EN to select same-cycle write-to-read forwarding.
REQ-040 SHALL, with RF_BYPASS_EN defined, capture wr_data instead of the bitline for a read port whose latched nonzero address equals wr_addr during SAMPLE with wr_en high.
REQ-041 SHALL, without RF_BYPASS_EN, always capture the bitline, i.e. the pre-write register value.

Verification
REQ-042 SHALL cover a basic read: write R3=16'hA5A5; read rd_addr1=3, rd_addr2=0 -> rd_valid 2 cycles after accept, rd_data1=16'hA5A5, rd_data2=16'h0000, rden1=16'h0008 in SAMPLE only.
REQ-043 SHALL cover the zero register: wr_en with wr_addr=0, wr_data=16'hFFFF -> write_reg=16'h0000; a later read of R0 returns 16'h0000.
REQ-044 SHALL cover a collision: R5=16'h1111, then in SAMPLE of a read of R5, write R5=16'h2222 -> rd_data1=16'h2222 with RF_BYPASS_EN, 16'h1111 without it.
REQ-045 SHALL cover backpressure: hold rd_ack low 5 cycles -> rd_valid and rd_data stable and rd_ready=0 throughout; rd_req ignored until IDLE.
REQ-046 SHALL cover reset mid-read: assert rst in SAMPLE -> rden1=rden2=0 immediately, rd_valid never asserts, rd_ready=1 in the first cycle after release.
REQ-047 SHALL cover same-register dual read: rd_addr1=rd_addr2=7 holding 16'h00C3 -> rden1=rden2=16'h0080, rd_data1=rd_data2=16'h00C3.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: read/write sequencer for a bitline register file; R0 reads as zero.
// Define RF_BYPASS_EN to forward a same-cycle write into a colliding SAMPLE read.
module regfile_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        rd_req,
  input  logic [3:0]  rd_addr1,
  input  logic [3:0]  rd_addr2,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [15:0] rd_data1,
  output logic [15:0] rd_data2,
  input  logic        rd_ack,
  output logic [15:0] write_reg,
  output logic [15:0] reg_d,
  output logic [15:0] rden1,
  output logic [15:0] rden2,
  input  logic [15:0] bitline1,
  input  logic [15:0] bitline2
);
  typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  a1_q, a1_d, a2_q, a2_d;
  logic [15:0] d1_q, d1_d, d2_q, d2_d;
  logic        valid_q, valid_d;
  logic        accept, sample, release_hold, hit1, hit2;
`ifdef RF_BYPASS_EN
  assign hit1 = wr_en && (wr_addr == a1_q);
  assign hit2 = wr_en && (wr_addr == a2_q);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  assign accept       = (state_q == IDLE) && rd_req;
  assign sample       = (state_q == SAMPLE);
  assign release_hold = (state_q == HOLD) && rd_ack;
  always_comb begin
    state_d = accept ? SAMPLE : sample ? HOLD : release_hold ? IDLE : state_q;
    a1_d    = accept ? rd_addr1 : a1_q;
    a2_d    = accept ? rd_addr2 : a2_q;
    d1_d    = !sample ? d1_q : (a1_q == 4'd0) ? 16'h0000 : hit1 ? wr_data : bitline1;
    d2_d    = !sample ? d2_q : (a2_q == 4'd0) ? 16'h0000 : hit2 ? wr_data : bitline2;
    valid_d = sample ? 1'b1 : release_hold ? 1'b0 : valid_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a1_q    <= 4'd0;
      a2_q    <= 4'd0;
      d1_q    <= 16'h0000;
      d2_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      valid_q <= valid_d;
    end
  end
  assign rd_ready  = (state_q == IDLE);
  assign rd_valid  = valid_q;
  assign rd_data1  = d1_q;
  assign rd_data2  = d2_q;
  assign reg_d     = wr_data;
  // Gated by rst so a write request during reset never reaches the array.
  assign write_reg = (rst && wr_en && wr_addr != 4'd0) ? 16'h1 << wr_addr : 16'h0000;
  assign rden1     = (sample && a1_q != 4'd0) ? 16'h1 << a1_q : 16'h0000;
  assign rden2     = (sample && a2_q != 4'd0) ? 16'h1 << a2_q : 16'h0000;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed and randomized reads/writes against an array model of the register file.
module tb_regfile_access_ctrl;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, wr_en, rd_req, rd_ack, rd_ready, rd_valid;
  logic [3:0]  wr_addr, rd_addr1, rd_addr2;
  logic [15:0] wr_data, rd_data1, rd_data2, write_reg, reg_d, rden1, rden2, bitline1, bitline2;
  logic [15:0] rf [16] = '{default: 16'h0000};
  logic [15:0] mem [16] = '{default: 16'h0000};
  int checks = 0;
  int failures = 0;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_ack(rd_ack),
    .write_reg(write_reg), .reg_d(reg_d), .rden1(rden1), .rden2(rden2),
    .bitline1(bitline1), .bitline2(bitline2)
  );

  always #5 clk = ~clk;

  // Physical register array driven only by the DUT's write/read enables.
  always @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (write_reg[i]) rf[i] <= reg_d;

  always_comb begin
    bitline1 = 16'h0000;
    bitline2 = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (rden1[i]) bitline1 = bitline1 | rf[i];
      if (rden2[i]) bitline2 = bitline2 | rf[i];
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] onehot(input logic [3:0] a);
    return (a == 4'd0) ? 16'h0000 : 16'h0001 << a;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst && wr_en && wr_addr != 4'd0) mem[wr_addr] = wr_data;
    #1;
  endtask

  task automatic wcycle(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    #1;
    check("write_reg", write_reg, (a == 4'd0) ? 16'h0000 : onehot(a));
    check("reg_d", reg_d, d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] x1, input logic [3:0] x2, input logic sw,
                    input logic [3:0] sa, input logic [15:0] sd, input int hold);
    logic [15:0] e1, e2;
    check("ready_idle", {15'd0, rd_ready}, 16'd1);
    rd_req = 1'b1; rd_addr1 = x1; rd_addr2 = x2; wr_en = 1'b0;
    tick();
    rd_req = 1'b0; rd_addr1 = 4'($urandom); rd_addr2 = 4'($urandom);
    wr_en = sw; wr_addr = sa; wr_data = sd;
    #1;
    check("rden1_sample", rden1, onehot(x1));
    check("rden2_sample", rden2, onehot(x2));
    check("ready_sample", {15'd0, rd_ready}, 16'd0);
    check("valid_sample", {15'd0, rd_valid}, 16'd0);
    check("write_reg_sample", write_reg, sw ? onehot(sa) : 16'h0000);
    e1 = (x1 == 4'd0) ? 16'h0000 : (BYP && sw && sa == x1) ? sd : mem[x1];
    e2 = (x2 == 4'd0) ? 16'h0000 : (BYP && sw && sa == x2) ? sd : mem[x2];
    tick();
    wr_en = 1'b0;
    check("valid_hold", {15'd0, rd_valid}, 16'd1);
    check("data1", rd_data1, e1);
    check("data2", rd_data2, e2);
    check("rden1_hold", rden1, 16'h0000);
    check("rden2_hold", rden2, 16'h0000);
    repeat (hold) begin
      rd_req = 1'b1; rd_ack = 1'b0;
      wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 16'($urandom);
      #1;
      check("write_reg_hold", write_reg, wr_en ? onehot(wr_addr) : 16'h0000);
      tick();
      check("valid_bp", {15'd0, rd_valid}, 16'd1);
      check("ready_bp", {15'd0, rd_ready}, 16'd0);
      check("data1_bp", rd_data1, e1);
      check("data2_bp", rd_data2, e2);
    end
    rd_ack = 1'b1; rd_req = 1'b1; wr_en = 1'b0;
    tick();
    rd_ack = 1'b0; rd_req = 1'b0;
    check("valid_after_ack", {15'd0, rd_valid}, 16'd0);
    check("ready_after_ack", {15'd0, rd_ready}, 16'd1);
    check("rden1_after_ack", rden1, 16'h0000);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    rd_req = 1'b0; rd_ack = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    #1;
    check("rst_write_reg", write_reg, 16'h0000);
    check("rst_rden1", rden1, 16'h0000);
    check("rst_valid", {15'd0, rd_valid}, 16'd0);
    check("rst_data1", rd_data1, 16'h0000);
    check("rst_data2", rd_data2, 16'h0000);
    tick(); tick();
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("ready_after_rst", {15'd0, rd_ready}, 16'd1);
    tick();
    // Basic read, zero register, collision, backpressure, dual read.
    wcycle(4'd3, 16'hA5A5);
    rd(4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 0);
    wcycle(4'd0, 16'hFFFF);
    rd(4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 0);
    wcycle(4'd5, 16'h1111);
    rd(4'd5, 4'd0, 1'b1, 4'd5, 16'h2222, 0);
    check("collision_value", rd_data1, BYP ? 16'h2222 : 16'h1111);
    wcycle(4'd9, 16'h1234);
    rd(4'd9, 4'd3, 1'b0, 4'd0, 16'h0000, 5);
    wcycle(4'd7, 16'h00C3);
    rd(4'd7, 4'd7, 1'b0, 4'd0, 16'h0000, 1);
    // Reset asserted while in SAMPLE aborts the read.
    rd_req = 1'b1; rd_addr1 = 4'd3; rd_addr2 = 4'd7;
    tick();
    rd_req = 1'b0;
    #1;
    check("mid_rden1", rden1, 16'h0008);
    rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hDEAD;
    #1;
    check("abort_rden1", rden1, 16'h0000);
    check("abort_rden2", rden2, 16'h0000);
    check("abort_write_reg", write_reg, 16'h0000);
    check("abort_valid", {15'd0, rd_valid}, 16'd0);
    tick();
    check("abort_valid_2", {15'd0, rd_valid}, 16'd0);
    tick();
    rst = 1'b1; wr_en = 1'b0;
    #1;
    check("abort_ready", {15'd0, rd_ready}, 16'd1);
    check("abort_data1", rd_data1, 16'h0000);
    tick();
    check("abort_valid_3", {15'd0, rd_valid}, 16'd0);
    check("abort_ready_2", {15'd0, rd_ready}, 16'd1);
    rd(4'd4, 4'd5, 1'b0, 4'd0, 16'h0000, 0);
    // Randomized traffic with occasional SAMPLE-cycle collisions.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) wcycle(4'($urandom), 16'($urandom));
      rd(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
         int'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
